fib_lookup: RTL
===============

Name: fib_lookup

Overview:
- Forwarding Information Base stage directly downstream of the PIT.
- When the PIT raises fib_out for an interest with no pending entry, this block:
  - absorbs the interest name byte-stream;
  - hashes every '/'-delimited prefix;
  - probes an external 1K x 12 FIB memory longest-prefix-first;
  - reports the egress face (3-bit port), or a miss.

Parameters:
- ADDR_W, 10, FIB memory index width. Also the hash width.
- MAX_LEN, 32, maximum name length in bytes. Longer names force a miss.
- MAX_COMP, 4, depth of the prefix snapshot stack.
- DELIM, 8'h2F, name component delimiter ('/').

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fib_in  in  1  start strobe, driven by PIT fib_out. One-cycle pulse.
- name_byte  in  8  name byte.
- name_valid  in  1  name_byte is valid this cycle.
- name_last  in  1  final name byte. Qualified by name_valid.
- mem_address  out  ADDR_W  FIB memory read index. Registered.
- mem_rd  out  1  memory read strobe.
- read_data  in  12  FIB entry: [11] valid, [10:3] tag, [2:0] port. Valid one cycle after the mem_rd cycle.
- out_port  out  3  egress port. Held until the next hit or reset.
- fib_hit  out  1  one-cycle pulse: lookup matched.
- fib_miss  out  1  one-cycle pulse: no prefix matched, or overflow.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is asynchronous and active-high. It forces state=IDLE and clears all of the following to 0:
  - mem_address, mem_rd;
  - out_port, fib_hit, fib_miss, busy;
  - hash, tag, byte count, stack pointer, overflow flag.
- Asserting reset mid-lookup aborts the lookup. No pulse is emitted.
- States: IDLE, COLLECT, PROBE, CHECK, DONE.
- IDLE:
  - fib_in=1 -> COLLECT; clear hash, tag, count, sp and ovf.
  - name_valid is ignored in IDLE.
- COLLECT: each name_valid byte b updates:
  - hash <= rotl1(hash) ^ zero-extended b;
  - tag <= tag + b (mod 256);
  - count++ (saturates at MAX_LEN+1; count > MAX_LEN sets ovf).
- Snapshot (push) rules:
  - b==DELIM with count>0: push the pre-update {hash, tag}.
  - name_last with b!=DELIM: push the post-update {hash, tag}.
  - Stack full: a new push overwrites the top slot, so the longest prefix is always on top.
- name_last exits COLLECT:
  - ovf=1 -> DONE with a miss. No memory access.
  - otherwise -> PROBE.
- PROBE (1 cycle): mem_rd=1, mem_address = top-of-stack hash; -> CHECK.
- CHECK (1 cycle): hit when read_data[11]=1 and read_data[10:3]=top tag.
  - hit: out_port <= read_data[2:0] -> DONE (hit).
  - no hit, more than one entry left: pop -> PROBE.
  - no hit, last entry: -> DONE (miss).
- DONE (1 cycle): fib_hit or fib_miss=1 -> IDLE.
- Latency from the name_last edge: DONE occurs 3 cycles later for a depth-1 hit. Each extra probe adds 2 cycles.
- fib_in while busy is ignored (no queuing). The upstream stage must wait for busy=0.
- name_valid outside COLLECT is ignored.
- mem_rd is 0 in every state except PROBE.

Test Plan:
- Name "a" (0x61, last); mem[0x061]=12'hB0D -> mem_address=0x061; fib_hit 3 cycles after last; out_port=5.
- Name "a/b" (61,2F,62); mem[0x1B8]=0, mem[0x061]=12'hB0D:
  - probes 0x1B8 then 0x061;
  - fib_hit 5 cycles after last; out_port=5.
- Name "a" with mem[0x061]=12'hB05 (tag 0x60, wrong) -> fib_miss 3 cycles after last; out_port unchanged.
- 33-byte name, last on byte 33 -> mem_rd never asserted; fib_miss 1 cycle after last.
- Reset asserted during CHECK -> busy=0 and all outputs 0 immediately. The next lookup of "a" hits normally.
- Second fib_in pulse during COLLECT -> ignored. Exactly one fib_hit or fib_miss pulse per accepted lookup.

Source files
------------

// File: rtl/fib_lookup.sv
// fib_lookup: FIB stage behind the PIT. It absorbs an interest name, hashes
// every '/'-delimited prefix, and probes an external FIB memory
// longest-prefix-first. It reports the egress port or a miss.
module fib_lookup #(
  parameter int          ADDR_W   = 10,
  parameter int          MAX_LEN  = 32,
  parameter int          MAX_COMP = 4,
  parameter logic [7:0]  DELIM    = 8'h2F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fib_in,
  input  logic [7:0]        name_byte,
  input  logic              name_valid,
  input  logic              name_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  input  logic [11:0]       read_data,
  output logic [2:0]        out_port,
  output logic              fib_hit,
  output logic              fib_miss,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_LEN + 2);
  localparam int SP_W  = $clog2(MAX_COMP + 1);
  localparam int IDX_W = (MAX_COMP > 1) ? $clog2(MAX_COMP) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, PROBE, CHECK, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] hash;
  logic [7:0]        tag;
  logic [CNT_W-1:0]  count;
  logic [SP_W-1:0]   sp;
  logic              ovf;
  logic [ADDR_W-1:0] stk_hash [MAX_COMP];
  logic [7:0]        stk_tag  [MAX_COMP];

  logic [ADDR_W-1:0] hash_upd;
  logic [7:0]        tag_upd;
  logic [CNT_W-1:0]  count_upd;
  logic              ovf_upd;
  logic              push_pre;
  logic              push_post;
  logic              do_push;
  logic [ADDR_W-1:0] push_hash;
  logic [7:0]        push_tag;
  logic [IDX_W-1:0]  push_slot;
  logic [SP_W-1:0]   sp_push;
  logic [SP_W-1:0]   sp_after;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  below_idx;
  logic [ADDR_W-1:0] top_hash_after;
  logic              entry_hit;

  // Per-byte hash/tag update, snapshot selection and probe-match decode
  always_comb begin
    hash_upd  = {hash[ADDR_W-2:0], hash[ADDR_W-1]} ^ {{(ADDR_W-8){1'b0}}, name_byte};
    tag_upd   = tag + name_byte;
    count_upd = (count == CNT_W'(MAX_LEN + 1)) ? count : count + CNT_W'(1);
    ovf_upd   = ovf | (count_upd > CNT_W'(MAX_LEN));
    // A delimiter closes the prefix seen so far; the final non-delimiter
    // byte closes the full name.
    push_pre  = (name_byte == DELIM) && (count != '0);
    push_post = name_last && (name_byte != DELIM);
    do_push   = push_pre | push_post;
    push_hash = push_pre ? hash : hash_upd;
    push_tag  = push_pre ? tag  : tag_upd;
    // When full, overwrite the top so the longest prefix stays on top.
    push_slot = (sp == SP_W'(MAX_COMP)) ? IDX_W'(MAX_COMP - 1) : IDX_W'(sp);
    sp_push   = (sp == SP_W'(MAX_COMP)) ? sp : sp + SP_W'(1);
    sp_after  = do_push ? sp_push : sp;
    top_idx   = IDX_W'(sp - SP_W'(1));
    below_idx = IDX_W'(sp - SP_W'(2));
    top_hash_after = do_push ? push_hash : stk_hash[top_idx];
    entry_hit = read_data[11] && (read_data[10:3] == stk_tag[top_idx]);
  end

  // Lookup FSM with registered memory strobe and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hash        <= '0;
      tag         <= '0;
      count       <= '0;
      sp          <= '0;
      ovf         <= 1'b0;
      mem_address <= '0;
      mem_rd      <= 1'b0;
      out_port    <= '0;
      fib_hit     <= 1'b0;
      fib_miss    <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < MAX_COMP; i++) begin
        stk_hash[i] <= '0;
        stk_tag[i]  <= '0;
      end
    end else begin
      mem_rd   <= 1'b0;
      fib_hit  <= 1'b0;
      fib_miss <= 1'b0;
      case (state)
        IDLE: begin
          if (fib_in) begin
            state <= COLLECT;
            busy  <= 1'b1;
            hash  <= '0;
            tag   <= '0;
            count <= '0;
            sp    <= '0;
            ovf   <= 1'b0;
          end
        end
        COLLECT: begin
          if (name_valid) begin
            hash  <= hash_upd;
            tag   <= tag_upd;
            count <= count_upd;
            ovf   <= ovf_upd;
            if (do_push) begin
              stk_hash[push_slot] <= push_hash;
              stk_tag[push_slot]  <= push_tag;
              sp                  <= sp_push;
            end
            if (name_last) begin
              // Overlong or prefix-less names miss without touching memory.
              if (ovf_upd || (sp_after == '0)) begin
                state    <= DONE;
                fib_miss <= 1'b1;
              end else begin
                state       <= PROBE;
                mem_rd      <= 1'b1;
                mem_address <= top_hash_after;
              end
            end
          end
        end
        PROBE: begin
          state <= CHECK;
        end
        CHECK: begin
          if (entry_hit) begin
            out_port <= read_data[2:0];
            fib_hit  <= 1'b1;
            state    <= DONE;
          end else if (sp > SP_W'(1)) begin
            sp          <= sp - SP_W'(1);
            mem_address <= stk_hash[below_idx];
            mem_rd      <= 1'b1;
            state       <= PROBE;
          end else begin
            fib_miss <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
